// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux (jalr > jal > branch > sequential) with word-alignment check.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_en,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc + XLEN'(PC_STEP);
    if (jalr_en) begin
      // JALR discards bit 0 of the computed address before the alignment check.
      next_pc = jalr_target & ~XLEN'(1);
    end else if (jal_en) begin
      next_pc = jal_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: PC register, imem handshake and decode-side valid/ready.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          XLEN     = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jal_en,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_target,
  output logic            misalign_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            misalign_err_q, misalign_err_d;

  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc          (pc_q),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jal_en      (jal_en),
    .jal_target  (jal_target),
    .jalr_en     (jalr_en),
    .jalr_target (jalr_target),
    .next_pc     (next_pc),
    .misaligned  (next_misaligned)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_valid_d  = instr_valid_q;
    imem_req_d     = imem_req_q;
    misalign_err_d = misalign_err_q;

    case (state_q)
      FETCH: begin
        // Request is registered, so the first cycle out of reset carries no request.
        if (imem_req_q && imem_ready) begin
          imem_req_d = 1'b0;
          state_d    = WAIT;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (next_misaligned) begin
            misalign_err_d = 1'b1;
            state_d        = ERR;
          end else begin
            pc_d       = next_pc;
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      ERR: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC[XLEN-1:0];
      instr_q        <= NOP_INSTR;
      instr_valid_q  <= 1'b0;
      imem_req_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      instr_valid_q  <= instr_valid_d;
      imem_req_q     <= imem_req_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign instr_valid  = instr_valid_q;
  assign instr        = instr_q;
  assign pc           = pc_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scripted scenarios plus randomized fetch/redirect traffic.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jal_en;
  logic [31:0] jal_target;
  logic        jalr_en;
  logic [31:0] jalr_target;
  logic        misalign_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: the address the next fetch must use.
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jal_en       (jal_en),
    .jal_target   (jal_target),
    .jalr_en      (jalr_en),
    .jalr_target  (jalr_target),
    .misalign_err (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect();
    br_taken    = 1'b0;
    br_target   = 32'h0;
    jal_en      = 1'b0;
    jal_target  = 32'h0;
    jalr_en     = 1'b0;
    jalr_target = 32'h0;
  endtask

  // Assert reset, check reset values, release; model restarts at RESET_PC.
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({imem_req, instr_valid, misalign_err} !== 3'b000 || pc !== 32'h0 ||
        imem_addr !== 32'h0 || instr !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL reset: req=%b valid=%b err=%b pc=%h addr=%h instr=%h expected 0,0,0,0,0,00000013",
               imem_req, instr_valid, misalign_err, pc, imem_addr, instr);
    end
    step();
    step();
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_low: req=%b expected 0", imem_req);
    end
    rst_n  = 1'b1;
    exp_pc = 32'h0;
  endtask

  // Fetch one word at exp_pc with rdly cycles of imem_ready low and vdly extra WAIT cycles.
  task automatic fetch_one(input logic [31:0] word, input int rdly, input int vdly);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_req: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
               imem_req, imem_addr, instr_valid, exp_pc);
    end
    for (int i = 0; i < rdly; i++) begin
      step();
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_held: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                 imem_req, imem_addr, instr_valid, exp_pc);
      end
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_accept: req=%b valid=%b expected 0,0", imem_req, instr_valid);
    end
    for (int i = 0; i < vdly; i++) step();
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== word || pc !== exp_pc) begin
      n_fail++;
      $display("FAIL instr_out: valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=%h",
               instr_valid, instr, pc, word, exp_pc);
    end
  endtask

  // Hold decode off for stall cycles (with a stray rvalid), then consume with the given redirect.
  task automatic consume(input int stall,
                         input logic br, input logic [31:0] brt,
                         input logic jl, input logic [31:0] jt,
                         input logic jr, input logic [31:0] jrt);
    logic [31:0] held_instr;
    logic [31:0] sel;
    held_instr = instr;
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      if (i == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~held_instr;
      end
      step();
      imem_rvalid = 1'b0;
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== held_instr || pc !== exp_pc || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL decode_stall: valid=%b instr=%h pc=%h req=%b expected 1,%h,%h,0",
                 instr_valid, instr, pc, imem_req, held_instr, exp_pc);
      end
    end
    br_taken = br;  br_target = brt;
    jal_en = jl;    jal_target = jt;
    jalr_en = jr;   jalr_target = jrt;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    clear_redirect();
    if (jr)      sel = {jrt[31:1], 1'b0};
    else if (jl) sel = jt;
    else if (br) sel = brt;
    else         sel = exp_pc + 32'd4;
    n_cmp++;
    if (sel % 4 != 0) begin
      if (misalign_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL misalign: err=%b valid=%b req=%b pc=%h expected 1,0,0,%h",
                 misalign_err, instr_valid, imem_req, pc, exp_pc);
      end
    end else begin
      exp_pc = sel;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
        n_fail++;
        $display("FAIL next_pc: req=%b addr=%h valid=%b err=%b expected 1,%h,0,0",
                 imem_req, imem_addr, instr_valid, misalign_err, exp_pc);
      end
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      fetch_one($urandom, 0, 0);
      consume(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_ready_stall();
    fetch_one($urandom, 3, 0);
    consume(4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    fetch_one($urandom, 0, 1);
    consume(0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    fetch_one($urandom, 1, 0);
    consume(1, 1'b1, 32'h44, 1'b1, 32'h88, 1'b1, 32'h101);
    fetch_one($urandom, 0, 0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    fetch_one($urandom, 0, 0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFD);
    fetch_one($urandom, 0, 0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      fetch_one($urandom, $urandom_range(0, 2), $urandom_range(0, 2));
      consume($urandom_range(0, 2),
              ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC,
              ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC,
              ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFD);
    end
  endtask

  task automatic test_misalign();
    fetch_one($urandom, 0, 0);
    consume(0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 32'h0);
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b1) begin
        n_fail++;
        $display("FAIL err_sticky: req=%b valid=%b err=%b expected 0,0,1",
                 imem_req, instr_valid, misalign_err);
      end
    end
    imem_ready = 1'b0;
    test_reset();
    fetch_one($urandom, 0, 0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    test_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL stale_rvalid: valid=%b instr=%h req=%b addr=%h expected 0,00000013,1,0",
               instr_valid, instr, imem_req, imem_addr);
    end
    fetch_one($urandom, 0, 0);
    consume(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    exp_pc      = 32'h0;
    clear_redirect();
    step();
    test_reset();
    test_sequential();
    test_ready_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_misalign();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
